ram64_stream_port: RTL and testbench
====================================

# ram64_stream_port

Sequencing front end that sits directly upstream of the 64-word RAM and owns its `in`, `address` and `load` inputs. It burst-writes a valid/ready word stream into consecutive RAM locations, or burst-reads consecutive locations out as a valid/ready word stream. Bursts start at any base address and wrap modulo 64. It lets a loader or debug port fill or dump RAM64 without driving per-word address and load timing.

## Interface
Parameters: none. Widths are fixed to the RAM64 word (16 bits) and address (6 bits).

- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-high; returns the block to IDLE.
- `start` input 1: burst request, sampled in IDLE only.
- `mode` input 1: 0 = write burst, 1 = read burst; sampled with `start`.
- `base` input 6: first RAM address of the burst; sampled with `start`.
- `count` input 7: words in the burst; 0 = empty burst, 65–127 clamp to 64; sampled with `start`.
- `s_data` input 16: write-stream data.
- `s_valid` input 1: write-stream valid.
- `s_ready` output 1: write-stream ready.
- `m_data` output 16: read-stream data (registered).
- `m_valid` output 1: read-stream valid.
- `m_ready` input 1: read-stream ready.
- `busy` output 1: high in WRITE, FETCH, HOLD.
- `done` output 1: one-cycle pulse at burst completion.
- `ram_in` output 16: to RAM64 `in`; always equals `s_data`.
- `ram_address` output 6: to RAM64 `address`; equals internal address register `addr`.
- `ram_load` output 1: to RAM64 `load`.
- `ram_out` input 16: from RAM64 `out`; combinational read of `ram_address`.

## Operation
- Internal registers: `state`, `addr[5:0]`, `remaining[6:0]`, `m_data[15:0]`, `m_valid`.
- FSM states: IDLE, WRITE, FETCH, HOLD, DONE.
- IDLE: `start`=1 loads `addr`←`base` and `remaining`←min(`count`,64).
  - Then: next state DONE if the clamped count is 0; else WRITE if `mode`=0; else FETCH.
  - `start`=0 stays in IDLE.
- WRITE: `s_ready`=1.
  - `ram_load` = `s_valid` (combinational; 0 in every other state).
  - On a handshake (`s_valid`&`s_ready`), RAM64 stores `s_data` at `addr` on that edge; `addr`←`addr`+1 mod 64; `remaining`←`remaining`−1.
  - When the handshake consumes the last word (`remaining`=1), next state is DONE.
- FETCH: `m_data`←`ram_out` (value at current `addr`); `m_valid`←1; next state HOLD.
- HOLD: `m_valid`=1 and `m_data` held stable until `m_ready`=1.
  - On a handshake: `m_valid`←0; `addr`←`addr`+1 mod 64; `remaining`←`remaining`−1.
  - Next state is DONE if `remaining` was 1, else FETCH.
- DONE: `done`=1 for exactly this cycle; next state IDLE. `addr` retains its final value.
- `start` outside IDLE is ignored and has no latched effect.
- Wrap: a burst with `base`+`count` > 64 continues from address 0 (e.g. base 62, count 4 → 62, 63, 0, 1).
- Read bursts never assert `ram_load`. Write bursts never assert `m_valid`.

## Timing
- Reset values: `state`=IDLE, `addr`=0, `remaining`=0, `m_data`=0, `m_valid`=0, `s_ready`=0, `ram_load`=0, `busy`=0, `done`=0.
- Reset is asynchronous. Asserting it mid-burst drops `ram_load` and `s_ready` immediately (both decode from `state`), so no partial write occurs after reset rises. RAM contents already written are kept.
- Write throughput is 1 word/cycle with `s_valid` held high. An N-word burst takes N WRITE cycles plus 1 DONE cycle.
- Read latency: `start` edge → FETCH cycle → `m_valid` high on the following cycle.
  - Throughput is 1 word per 2 cycles with `m_ready` held high.
- Empty burst (`count`=0): `done` pulses the cycle after `start`. `busy` never rises; no RAM access occurs.
- `busy` and `done` are never high together. `busy` falls in the same cycle `done` rises.
- Back-to-back bursts: `start` may be accepted in the first IDLE cycle after DONE.

## Test plan
- Write 4 words 0x1111, 0x2222, 0x3333, 0x4444 from `base` 5 with `s_valid` held high:
  - `ram_load` high exactly 4 cycles, with `ram_address` = 5, 6, 7, 8.
  - `done` pulses on cycle 5.
  - A RAM readback of addresses 5–8 returns those values.
- Write burst with `base` 62, `count` 4, then read the same range with `m_ready` held high:
  - Writes land at 62, 63, 0, 1.
  - The read stream yields the same 4 words in order; `m_valid` rises 2 cycles after `start`, then on every second cycle.
- Read backpressure: hold `m_ready`=0 for 5 cycles during HOLD.
  - `m_data` stays stable and `addr` is unchanged.
  - Releasing `m_ready` advances exactly one word.
- `count`=0 and `count`=100:
  - 0 → `done` the next cycle, no `ram_load`.
  - 100 → exactly 64 write handshakes, then `done`.
- Assert `reset` during a write burst after the 2nd handshake, with `s_valid` high:
  - `ram_load` and `s_ready` drop immediately; all outputs read their reset values.
  - The 3rd RAM location keeps its old value.
- Pulse `start` while `busy`=1 with different `base`/`mode`: the current burst completes unchanged, and no second burst runs.

Source files
------------

// File: rtl/ram64_stream_port.sv
// ram64_stream_port: valid/ready burst sequencer that owns the RAM64 in/address/load inputs.
// Write bursts store one streamed word per handshake; read bursts fetch then hold each word.
module ram64_stream_port (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [5:0]  base,
    input  logic [6:0]  count,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [15:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] ram_in,
    output logic [5:0]  ram_address,
    output logic        ram_load,
    input  logic [15:0] ram_out
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WRITE = 3'd1;
    localparam logic [2:0] FETCH = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0] state;
    logic [5:0] addr;
    logic [6:0] remaining;
    logic [6:0] clamped;

    always_comb begin
        clamped     = count > 7'd64 ? 7'd64 : count;
        s_ready     = state == WRITE;
        ram_load    = s_ready & s_valid;
        busy        = state == WRITE || state == FETCH || state == HOLD;
        done        = state == DONE;
        ram_in      = s_data;
        ram_address = addr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= 6'd0;
            remaining <= 7'd0;
            m_data    <= 16'd0;
            m_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    addr      <= base;
                    remaining <= clamped;
                    state     <= clamped == 7'd0 ? DONE : mode ? FETCH : WRITE;
                end
                WRITE: if (s_valid) begin
                    addr      <= addr + 6'd1;
                    remaining <= remaining - 7'd1;
                    if (remaining == 7'd1) state <= DONE;
                end
                FETCH: begin
                    m_data  <= ram_out;
                    m_valid <= 1'b1;
                    state   <= HOLD;
                end
                HOLD: if (m_ready) begin
                    m_valid   <= 1'b0;
                    addr      <= addr + 6'd1;
                    remaining <= remaining - 7'd1;
                    state     <= remaining == 7'd1 ? DONE : FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram64_stream_port.sv
// tb_ram64_stream_port: randomized bursts against a word-level RAM image and burst-order model.
module tb_ram64_stream_port;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0;
    logic        s_valid = 1'b0, m_ready = 1'b0;
    logic [5:0]  base = 6'd0;
    logic [6:0]  count = 7'd0;
    logic [15:0] s_data = 16'd0;
    logic        s_ready, m_valid, busy, done, ram_load;
    logic [15:0] m_data, ram_in, ram_out;
    logic [5:0]  ram_address;
    logic [15:0] mem [64];
    logic [15:0] ref_mem [64];
    logic [15:0] wdata [64];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;
    assign ram_out = mem[ram_address];

    ram64_stream_port dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .base(base), .count(count),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .done(done), .ram_in(ram_in),
        .ram_address(ram_address), .ram_load(ram_load), .ram_out(ram_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic junk();
        start = 1'($urandom_range(0, 1));
        mode  = 1'($urandom_range(0, 1));
        base  = 6'($urandom);
        count = 7'($urandom);
    endtask

    task automatic fill_wdata();
        for (int i = 0; i < 64; i++) wdata[i] = 16'($urandom);
    endtask

    task automatic begin_burst(input logic md, input logic [5:0] b, input logic [6:0] c);
        @(negedge clk);
        start = 1'b1; mode = md; base = b; count = c; s_valid = 1'b0; m_ready = 1'b0;
        #1;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_load", ram_load, 0);
    endtask

    task automatic end_burst();
        @(negedge clk);
        start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        #1;
        check("post_busy", busy, 0);
        check("post_done", done, 0);
    endtask

    task automatic write_burst(input logic [5:0] b, input logic [6:0] c, input bit full);
        int n, k;
        n = c > 64 ? 64 : int'(c);
        k = 0;
        begin_burst(1'b0, b, c);
        for (int cyc = 1; ; cyc++) begin
            @(negedge clk);
            junk();
            s_valid = full ? 1'b1 : 1'($urandom_range(0, 1));
            s_data = wdata[k % 64];
            #1;
            if (cyc > 400) begin
                check("w_timeout", cyc, 0);
                break;
            end
            if (done) begin
                check("w_count", k, n);
                if (full) check("w_done_cyc", cyc, n + 1);
                check("w_done_busy", busy, 0);
                check("w_done_load", ram_load, 0);
                break;
            end
            check("w_busy", busy, 1);
            check("w_ready", s_ready, 1);
            check("w_mvalid", m_valid, 0);
            check("w_load", ram_load, s_valid);
            check("w_in", ram_in, s_data);
            if (s_valid) begin
                check("w_addr", ram_address, (b + k) % 64);
                ref_mem[(b + k) % 64] = s_data;
                k++;
            end
        end
        end_burst();
    endtask

    task automatic read_burst(input logic [5:0] b, input logic [6:0] c, input bit full);
        int n, k;
        n = c > 64 ? 64 : int'(c);
        k = 0;
        begin_burst(1'b1, b, c);
        for (int cyc = 1; ; cyc++) begin
            @(negedge clk);
            junk();
            m_ready = full ? 1'b1 : 1'($urandom_range(0, 1));
            s_valid = 1'($urandom_range(0, 1));
            #1;
            if (cyc > 600) begin
                check("r_timeout", cyc, 0);
                break;
            end
            if (done) begin
                check("r_count", k, n);
                if (full) check("r_done_cyc", cyc, 2 * n + 1);
                check("r_done_busy", busy, 0);
                break;
            end
            check("r_busy", busy, 1);
            check("r_sready", s_ready, 0);
            check("r_load", ram_load, 0);
            if (full) check("r_vphase", m_valid, cyc % 2 == 0);
            if (m_valid) begin
                check("r_data", m_data, ref_mem[(b + k) % 64]);
                check("r_addr", ram_address, (b + k) % 64);
                if (m_ready) k++;
            end
        end
        end_burst();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            mem[i] <= v;
            ref_mem[i] = v;
        end
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sready", s_ready, 0);
        check("rst_load", ram_load, 0);
        check("rst_mvalid", m_valid, 0);
        check("rst_mdata", m_data, 0);
        check("rst_addr", ram_address, 0);
        @(negedge clk);
        reset = 1'b0;

        wdata[0] = 16'h1111; wdata[1] = 16'h2222; wdata[2] = 16'h3333; wdata[3] = 16'h4444;
        write_burst(6'd5, 7'd4, 1'b1);
        check("ram5", mem[5], 16'h1111);
        check("ram6", mem[6], 16'h2222);
        check("ram7", mem[7], 16'h3333);
        check("ram8", mem[8], 16'h4444);
        read_burst(6'd5, 7'd4, 1'b1);

        fill_wdata();
        write_burst(6'd62, 7'd4, 1'b1);
        check("wrap62", mem[62], wdata[0]);
        check("wrap63", mem[63], wdata[1]);
        check("wrap0", mem[0], wdata[2]);
        check("wrap1", mem[1], wdata[3]);
        read_burst(6'd62, 7'd4, 1'b1);

        begin_burst(1'b1, 6'd10, 7'd3);
        @(negedge clk); start = 1'b0; #1;
        check("bp_fetch", m_valid, 0);
        repeat (5) begin
            @(negedge clk); m_ready = 1'b0; #1;
            check("bp_valid", m_valid, 1);
            check("bp_data", m_data, ref_mem[10]);
            check("bp_addr", ram_address, 10);
        end
        @(negedge clk); m_ready = 1'b1; #1;
        check("bp_rel_data", m_data, ref_mem[10]);
        @(negedge clk); m_ready = 1'b0; #1;
        check("bp_adv_valid", m_valid, 0);
        check("bp_adv_addr", ram_address, 11);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk); m_ready = 1'b1; #1;
        end
        check("bp_done", done, 1);
        end_burst();

        write_burst(6'd7, 7'd0, 1'b1);
        read_burst(6'd7, 7'd0, 1'b1);
        fill_wdata();
        write_burst(6'd0, 7'd100, 1'b1);

        fill_wdata();
        begin_burst(1'b0, 6'd20, 7'd8);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); start = 1'b0; s_valid = 1'b1; s_data = wdata[k]; #1;
            ref_mem[20 + k] = s_data;
        end
        @(negedge clk); s_valid = 1'b1; s_data = ~ref_mem[22]; #1;
        check("pre_rst_load", ram_load, 1);
        reset = 1'b1; #1;
        check("mid_rst_load", ram_load, 0);
        check("mid_rst_sready", s_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_mvalid", m_valid, 0);
        check("mid_rst_mdata", m_data, 0);
        check("mid_rst_addr", ram_address, 0);
        @(negedge clk); reset = 1'b0; s_valid = 1'b0; #1;
        check("rst_keep20", mem[20], ref_mem[20]);
        check("rst_keep21", mem[21], ref_mem[21]);
        check("rst_keep22", mem[22], ref_mem[22]);
        check("rst_idle", busy, 0);

        for (int t = 0; t < 30; t++) begin
            logic md;
            logic [5:0] b;
            logic [6:0] c;
            bit full;
            md = 1'($urandom_range(0, 1));
            b = 6'($urandom);
            c = $urandom_range(0, 3) == 0 ? 7'($urandom_range(0, 4)) : 7'($urandom_range(0, 127));
            full = $urandom_range(0, 3) == 0;
            fill_wdata();
            if (md) read_burst(b, c, full);
            else write_burst(b, c, full);
        end
        for (int i = 0; i < 64; i++) check("final_ram", mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
